// File: rtl/csr_pkg.sv
// Shared types and constants for the CSR access controller.
package csr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } csr_state_e;

  // Zicsr funct3 encodings
  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  // funct3 values with no Zicsr meaning under the SYSTEM opcode
  localparam logic [2:0] F3_ILL_A = 3'b000;
  localparam logic [2:0] F3_ILL_B = 3'b100;

  // Cause reported when the controller traps locally (illegal funct3 or no response)
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b00;

  // Bit positions inside csr_op
  localparam int OP_R_BIT = 1;
  localparam int OP_W_BIT = 0;

endpackage

// File: rtl/csr_op_dec.sv
// Zicsr operation decode: which of read/write the instruction really performs.
module csr_op_dec
  import csr_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_uimm,
  output logic [1:0] o_op,
  output logic       o_illegal
);

  // CSRRW/CSRRWI with rd=0 skip the read; set/clear with a zero source skip the write.
  always_comb begin
    o_op            = '0;
    o_op[OP_R_BIT]  = !((i_funct3[1:0] == 2'b01) && (i_rd == 5'd0));
    o_op[OP_W_BIT]  = !(i_funct3[1] && (i_uimm == 5'd0));
    o_illegal       = (i_funct3 == F3_ILL_A) || (i_funct3 == F3_ILL_B);
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sequences one Zicsr instruction at a time onto the shared CSR bus.
//
//  state | meaning
//  IDLE  | ready for a new instruction from execute
//  ISSUE | csr_valid strobe on the bus (one cycle)
//  WAIT  | bus request held, waiting for csr_rvalid or timeout
//  RESP  | result held for writeback until wb_ready
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int REG_WIDTH   = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [4:0]            req_uimm,
  input  logic [4:0]            req_rd,
  input  logic [REG_WIDTH-1:0]  req_rs1_val,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  flush,
  output logic                  csr_valid,
  output logic [1:0]            csr_op,
  output logic [2:0]            csr_funct3,
  output logic [4:0]            csr_imm,
  output logic [REG_WIDTH-1:0]  csr_rs1_val,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic                  csr_rrsp,
  input  logic [ADDR_WIDTH-1:0] csr_rdata,
  input  logic                  csr_rvalid,
  input  logic [2:0]            csr_reg_rsp,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic                  wb_we,
  output logic [4:0]            wb_rd,
  output logic [ADDR_WIDTH-1:0] wb_data,
  output logic                  exc_valid,
  output logic [1:0]            exc_cause
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  csr_state_e            r_state, w_state_nxt;
  logic [2:0]            r_funct3;
  logic [4:0]            r_uimm;
  logic [4:0]            r_rd;
  logic [REG_WIDTH-1:0]  r_rs1_val;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_op;
  logic                  r_exc;
  logic [1:0]            r_cause;
  logic [ADDR_WIDTH-1:0] r_rdata;
  logic                  r_kill;
  logic [CNT_W-1:0]      r_cnt;

  logic [1:0] w_dec_op;
  logic       w_dec_illegal;
  logic       w_accept;
  logic       w_capture;
  logic       w_timeout;
  logic       w_bus_act;
  logic       w_kill;

  csr_op_dec u_op_dec (
    .i_funct3  (req_funct3),
    .i_rd      (req_rd),
    .i_uimm    (req_uimm),
    .o_op      (w_dec_op),
    .o_illegal (w_dec_illegal)
  );

  assign w_bus_act = (r_state == ISSUE) || (r_state == WAIT);
  assign w_kill    = r_kill || flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and all outputs; bus fields are forced to 0 outside ISSUE/WAIT
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    req_ready   = (r_state == IDLE);
    csr_valid   = (r_state == ISSUE);
    csr_op      = w_bus_act ? r_op      : '0;
    csr_funct3  = w_bus_act ? r_funct3  : '0;
    csr_imm     = w_bus_act ? r_uimm    : '0;
    csr_rs1_val = w_bus_act ? r_rs1_val : '0;
    csr_addr    = w_bus_act ? r_addr    : '0;
    csr_rrsp    = w_bus_act && csr_rvalid;
    wb_valid    = (r_state == RESP);
    wb_we       = (r_state == RESP) && !r_exc && r_op[OP_R_BIT] && (r_rd != 5'd0);
    wb_rd       = (r_state == RESP) ? r_rd : '0;
    wb_data     = ((r_state == RESP) && !r_exc) ? r_rdata : '0;
    exc_valid   = (r_state == RESP) && r_exc;
    exc_cause   = (r_state == RESP) ? r_cause : '0;

    case (r_state)
      IDLE: begin
        if (req_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = w_dec_illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (csr_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = w_kill ? IDLE : RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (csr_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = w_kill ? IDLE : RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = w_kill ? IDLE : RESP;
        end
      end
      RESP: begin
        if (wb_ready || flush) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request latch, response capture, timeout counter and sticky kill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3  <= '0;
      r_uimm    <= '0;
      r_rd      <= '0;
      r_rs1_val <= '0;
      r_addr    <= '0;
      r_op      <= '0;
      r_exc     <= 1'b0;
      r_cause   <= '0;
      r_rdata   <= '0;
      r_kill    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_funct3  <= req_funct3;
        r_uimm    <= req_uimm;
        r_rd      <= req_rd;
        r_rs1_val <= req_rs1_val;
        r_addr    <= req_addr;
        r_op      <= w_dec_op;
        r_exc     <= w_dec_illegal;
        r_cause   <= CAUSE_ILLEGAL;
        r_rdata   <= '0;
      end
      if (w_capture) begin
        r_rdata <= csr_rdata;
        r_exc   <= csr_reg_rsp[2];
        r_cause <= csr_reg_rsp[2] ? csr_reg_rsp[1:0] : CAUSE_ILLEGAL;
      end
      if (w_timeout) begin
        r_rdata <= '0;
        r_exc   <= 1'b1;
        r_cause <= CAUSE_ILLEGAL;
      end
      if (r_state == ISSUE) r_cnt <= '0;
      else if ((r_state == WAIT) && !w_timeout) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == IDLE) r_kill <= 1'b0;
      else if (w_bus_act && flush) r_kill <= 1'b1;
    end
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed self-checking bench for csr_access_ctrl.
module tb_csr_access_ctrl;
  import csr_pkg::*;

  localparam int AW = 32;
  localparam int RW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_funct3 = '0;
  logic [4:0]    req_uimm = '0;
  logic [4:0]    req_rd = '0;
  logic [RW-1:0] req_rs1_val = '0;
  logic [AW-1:0] req_addr = '0;
  logic          flush = 1'b0;
  logic          csr_valid;
  logic [1:0]    csr_op;
  logic [2:0]    csr_funct3;
  logic [4:0]    csr_imm;
  logic [RW-1:0] csr_rs1_val;
  logic [AW-1:0] csr_addr;
  logic          csr_rrsp;
  logic [AW-1:0] csr_rdata = '0;
  logic          csr_rvalid = 1'b0;
  logic [2:0]    csr_reg_rsp = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [AW-1:0] wb_data;
  logic          exc_valid;
  logic [1:0]    exc_cause;

  int n_total = 0;
  int n_bad   = 0;

  csr_access_ctrl #(.ADDR_WIDTH(AW), .REG_WIDTH(RW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_uimm(req_uimm), .req_rd(req_rd), .req_rs1_val(req_rs1_val),
    .req_addr(req_addr), .flush(flush),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_funct3(csr_funct3),
    .csr_imm(csr_imm), .csr_rs1_val(csr_rs1_val), .csr_addr(csr_addr),
    .csr_rrsp(csr_rrsp), .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid),
    .csr_reg_rsp(csr_reg_rsp),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Present one request for a single cycle; returns with the DUT in ISSUE (or RESP if illegal).
  task automatic send(input logic [2:0] f3, input logic [4:0] uimm, input logic [4:0] rd,
                      input logic [RW-1:0] rs1, input logic [AW-1:0] addr);
    req_valid   = 1'b1;
    req_funct3  = f3;
    req_uimm    = uimm;
    req_rd      = rd;
    req_rs1_val = rs1;
    req_addr    = addr;
    nxt();
    req_valid = 1'b0;
    #1;
  endtask

  task automatic wb_accept();
    wb_ready = 1'b1;
    nxt();
    wb_ready = 1'b0;
    #1;
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_csr_valid", csr_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_csr_addr", csr_addr, 0);
    nxt();
    rst_n = 1'b1;
    nxt();

    // CSRRS read-only, response after 3 cycles
    send(CSRRS, 5'd0, 5'd5, 32'h0, 32'h3A0);
    chk("t1_csr_valid", csr_valid, 1);
    chk("t1_csr_op", csr_op, 2'b10);
    chk("t1_csr_addr", csr_addr, 32'h3A0);
    chk("t1_csr_funct3", csr_funct3, CSRRS);
    nxt(); #1;
    chk("t1_wait_valid", csr_valid, 0);
    chk("t1_wait_addr", csr_addr, 32'h3A0);
    chk("t1_wait_op", csr_op, 2'b10);
    nxt();
    nxt();
    csr_rvalid = 1'b1; csr_rdata = 32'h1F; csr_reg_rsp = 3'b000; #1;
    chk("t1_rrsp", csr_rrsp, 1);
    nxt(); csr_rvalid = 1'b0; csr_rdata = '0; #1;
    chk("t1_wb_valid", wb_valid, 1);
    chk("t1_wb_data", wb_data, 32'h1F);
    chk("t1_wb_we", wb_we, 1);
    chk("t1_wb_rd", wb_rd, 5);
    chk("t1_exc", exc_valid, 0);
    chk("t1_resp_addr", csr_addr, 0);
    chk("t1_resp_rrsp", csr_rrsp, 0);
    wb_accept();
    chk("t1_idle_wb", wb_valid, 0);
    chk("t1_idle_ready", req_ready, 1);

    // CSRRW rd=0, response in the ISSUE cycle
    send(CSRRW, 5'd3, 5'd0, 32'hDEAD, 32'h3B0);
    chk("t2_csr_op", csr_op, 2'b01);
    chk("t2_rs1", csr_rs1_val, 32'hDEAD);
    chk("t2_imm", csr_imm, 5'd3);
    csr_rvalid = 1'b1; csr_rdata = 32'h55; #1;
    chk("t2_rrsp", csr_rrsp, 1);
    nxt(); csr_rvalid = 1'b0; #1;
    chk("t2_wb_valid", wb_valid, 1);
    chk("t2_wb_we", wb_we, 0);
    chk("t2_wb_data", wb_data, 32'h55);
    chk("t2_rrsp_pulse", csr_rrsp, 0);
    wb_accept();

    // Unmapped address: timeout
    send(CSRRS, 5'd0, 5'd3, 32'h0, 32'h7C0);
    n = 0;
    while (!wb_valid && n < 40) begin
      nxt(); #1;
      n++;
    end
    chk("t3_latency", n, TO + 1);
    chk("t3_exc", exc_valid, 1);
    chk("t3_cause", exc_cause, CAUSE_ILLEGAL);
    chk("t3_wb_we", wb_we, 0);
    chk("t3_wb_data", wb_data, 0);
    wb_accept();
    csr_rvalid = 1'b1; #1;
    chk("t3_late_rrsp", csr_rrsp, 0);
    chk("t3_late_ready", req_ready, 1);
    nxt(); csr_rvalid = 1'b0; #1;
    chk("t3_late_state", req_ready, 1);

    // Illegal funct3: no bus access
    send(3'b100, 5'd1, 5'd4, 32'h0, 32'h300);
    chk("t4_csr_valid", csr_valid, 0);
    chk("t4_wb_valid", wb_valid, 1);
    chk("t4_exc", exc_valid, 1);
    chk("t4_cause", exc_cause, 2'b00);
    wb_accept();

    // Peripheral exception, writeback stalled 5 cycles
    send(CSRRS, 5'd0, 5'd7, 32'h0, 32'h3A1);
    csr_rvalid = 1'b1; csr_rdata = 32'hAB; csr_reg_rsp = 3'b110;
    nxt(); csr_rvalid = 1'b0; csr_reg_rsp = 3'b000; #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_wb_valid", wb_valid, 1);
      chk("t5_exc", exc_valid, 1);
      chk("t5_cause", exc_cause, 2'b10);
      chk("t5_wb_we", wb_we, 0);
      chk("t5_wb_data", wb_data, 0);
      nxt(); #1;
    end
    wb_accept();

    // Flush during WAIT: bus completes, no writeback
    send(CSRRS, 5'd0, 5'd2, 32'h0, 32'h3A2);
    nxt();
    flush = 1'b1;
    nxt(); flush = 1'b0;
    nxt();
    csr_rvalid = 1'b1; csr_rdata = 32'h77; #1;
    chk("t6_rrsp", csr_rrsp, 1);
    nxt(); csr_rvalid = 1'b0; #1;
    chk("t6_wb_valid", wb_valid, 0);
    chk("t6_ready", req_ready, 1);

    // Flush in the accept cycle drops the request
    flush = 1'b1;
    send(CSRRS, 5'd0, 5'd2, 32'h0, 32'h3A3);
    flush = 1'b0;
    chk("t7_ready", req_ready, 1);
    chk("t7_csr_valid", csr_valid, 0);

    // Reset during WAIT
    send(CSRRC, 5'd0, 5'd9, 32'h3, 32'h3A4);
    nxt();
    rst_n = 1'b0; #1;
    chk("t8_csr_valid", csr_valid, 0);
    chk("t8_ready", req_ready, 1);
    chk("t8_addr", csr_addr, 0);
    nxt(); rst_n = 1'b1;
    nxt(); #1;
    chk("t8_after_ready", req_ready, 1);
    chk("t8_after_wb", wb_valid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
